// File: rtl/atm_pin_entry.sv
// PIN-entry controller: buffers BCD keypad digits, checks them against the card PIN,
// counts wrong attempts and drives the session timer. Optional lockout: ATM_PIN_LOCKOUT_EN.
module atm_pin_entry #(
  parameter int PIN_DIGITS = 4,
  parameter int MAX_TRIES  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    card_in,
  input  logic [4*PIN_DIGITS-1:0] stored_pin,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    key_enter,
  input  logic                    key_cancel,
  input  logic                    timer_timeout,
  output logic                    timer_start,
  output logic                    timer_restart,
  output logic [3:0]              digits_entered,
  output logic [2:0]              tries_left,
  output logic                    pin_ok,
  output logic                    pin_fail,
  output logic                    locked,
  output logic                    aborted
);

  localparam int         BW         = 4 * PIN_DIGITS;
  localparam logic [3:0] FULL_CNT   = 4'(PIN_DIGITS);
  localparam logic [2:0] TRIES_INIT = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_GRANTED = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0] digits_q, digits_d;
  logic [2:0] tries_q, tries_d;
  logic       start_q, start_d;
  logic       restart_q, restart_d;
  logic       ok_q, ok_d;
  logic       fail_q, fail_d;
  logic       locked_q, locked_d;
  logic       aborted_q, aborted_d;

  logic digit_is_bcd;
  logic has_room;
  logic pin_match;

  assign digit_is_bcd = (key_digit <= 4'd9);
  assign has_room     = (digits_q < FULL_CNT);
  // Unused buffer slots are always zero, so a short entry can never alias a full one.
  assign pin_match    = (digits_q == FULL_CNT) && (buf_q == stored_pin);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    digits_d  = digits_q;
    tries_d   = tries_q;
    restart_d = 1'b0;
    fail_d    = 1'b0;
    aborted_d = 1'b0;

    if (!card_in) begin
      state_d  = S_IDLE;
      buf_d    = '0;
      digits_d = 4'd0;
      tries_d  = TRIES_INIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_ENTRY;
          buf_d     = '0;
          digits_d  = 4'd0;
          tries_d   = TRIES_INIT;
          restart_d = 1'b1;
        end
        S_ENTRY: begin
          if (timer_timeout || key_cancel) begin
            state_d   = S_IDLE;
            buf_d     = '0;
            digits_d  = 4'd0;
            aborted_d = 1'b1;
          end else if (key_enter) begin
            state_d = S_CHECK;
          end else if (key_valid && digit_is_bcd && has_room) begin
            buf_d     = buf_q | (BW'(key_digit) << {digits_q, 2'b00});
            digits_d  = digits_q + 4'd1;
            restart_d = 1'b1;
          end else begin
            state_d = S_ENTRY;
          end
        end
        S_CHECK: begin
          if (pin_match) begin
            state_d = S_GRANTED;
          end else begin
            fail_d = 1'b1;
`ifdef ATM_PIN_LOCKOUT_EN
            tries_d = tries_q - 3'd1;
            if (tries_q == 3'd1) begin
              state_d = S_LOCKED;
            end else begin
              state_d   = S_ENTRY;
              buf_d     = '0;
              digits_d  = 4'd0;
              restart_d = 1'b1;
            end
`else
            state_d   = S_ENTRY;
            buf_d     = '0;
            digits_d  = 4'd0;
            restart_d = 1'b1;
`endif
          end
        end
        S_GRANTED: state_d = S_GRANTED;
        S_LOCKED:  state_d = S_LOCKED;
        default: begin
          state_d  = S_IDLE;
          buf_d    = '0;
          digits_d = 4'd0;
          tries_d  = TRIES_INIT;
        end
      endcase
    end

    start_d = (state_d == S_ENTRY);
    ok_d    = (state_d == S_GRANTED);
`ifdef ATM_PIN_LOCKOUT_EN
    locked_d = (state_d == S_LOCKED);
`else
    locked_d = 1'b0;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      digits_q  <= 4'd0;
      tries_q   <= TRIES_INIT;
      start_q   <= 1'b0;
      restart_q <= 1'b0;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
      locked_q  <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      digits_q  <= digits_d;
      tries_q   <= tries_d;
      start_q   <= start_d;
      restart_q <= restart_d;
      ok_q      <= ok_d;
      fail_q    <= fail_d;
      locked_q  <= locked_d;
      aborted_q <= aborted_d;
    end
  end

  assign timer_start    = start_q;
  assign timer_restart  = restart_q;
  assign digits_entered = digits_q;
  assign tries_left     = tries_q;
  assign pin_ok         = ok_q;
  assign pin_fail       = fail_q;
  assign locked         = locked_q;
  assign aborted        = aborted_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: directed steps plus random keypad traffic, checked every
// cycle against a session-level reference model (entered digits kept in a queue).
module tb_atm_pin_entry;
  localparam int PD = 4;
  localparam int MT = 3;
`ifdef ATM_PIN_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          card_in;
  logic [4*PD-1:0] stored_pin;
  logic          key_valid;
  logic [3:0]    key_digit;
  logic          key_enter;
  logic          key_cancel;
  logic          timer_timeout;
  logic          timer_start;
  logic          timer_restart;
  logic [3:0]    digits_entered;
  logic [2:0]    tries_left;
  logic          pin_ok;
  logic          pin_fail;
  logic          locked;
  logic          aborted;

  atm_pin_entry #(.PIN_DIGITS(PD), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .stored_pin(stored_pin),
    .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
    .key_cancel(key_cancel), .timer_timeout(timer_timeout),
    .timer_start(timer_start), .timer_restart(timer_restart),
    .digits_entered(digits_entered), .tries_left(tries_left),
    .pin_ok(pin_ok), .pin_fail(pin_fail), .locked(locked), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Session model: what the customer has done so far, not how the RTL encodes it.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_GRANT = 3, M_LOCK = 4;
  int m_mode  = M_IDLE;
  int m_keys[$];
  int m_tries = MT;
  bit e_restart, e_fail, e_abort;

  function automatic bit pin_matches();
    if (m_keys.size() != PD) return 1'b0;
    for (int i = 0; i < PD; i++)
      if (m_keys[i] != int'((stored_pin >> (4*i)) & 16'hF)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    e_restart = 1'b0; e_fail = 1'b0; e_abort = 1'b0;
    if (rst || !card_in) begin
      m_mode = M_IDLE; m_keys.delete(); m_tries = MT;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_mode = M_ENTRY; m_keys.delete(); m_tries = MT; e_restart = 1'b1;
        end
        M_ENTRY: begin
          if (timer_timeout || key_cancel) begin
            e_abort = 1'b1; m_mode = M_IDLE; m_keys.delete();
          end else if (key_enter) begin
            m_mode = M_CHECK;
          end else if (key_valid && key_digit < 4'd10 && m_keys.size() < PD) begin
            m_keys.push_back(int'(key_digit)); e_restart = 1'b1;
          end
        end
        M_CHECK: begin
          if (pin_matches()) begin
            m_mode = M_GRANT;
          end else begin
            e_fail = 1'b1;
            if (LOCK_EN) m_tries = m_tries - 1;
            if (m_tries == 0) begin
              m_mode = M_LOCK;
            end else begin
              m_mode = M_ENTRY; m_keys.delete(); e_restart = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("timer_start",    32'(timer_start),    32'(m_mode == M_ENTRY));
    chk("timer_restart",  32'(timer_restart),  32'(e_restart));
    chk("digits_entered", 32'(digits_entered), 32'(m_keys.size()));
    chk("tries_left",     32'(tries_left),     32'(m_tries));
    chk("pin_ok",         32'(pin_ok),         32'(m_mode == M_GRANT));
    chk("pin_fail",       32'(pin_fail),       32'(e_fail));
    chk("locked",         32'(locked),         32'(m_mode == M_LOCK));
    chk("aborted",        32'(aborted),        32'(e_abort));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic clear_strobes();
    key_valid = 1'b0; key_enter = 1'b0; key_cancel = 1'b0; timer_timeout = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; tick(); clear_strobes();
  endtask

  task automatic enter_key();
    key_enter = 1'b1; tick(); clear_strobes();
  endtask

  task automatic reinsert();
    card_in = 1'b0; tick(); card_in = 1'b1; tick();
  endtask

  initial begin
    logic [15:0] tmp;
    rst = 1'b1; card_in = 1'b0; stored_pin = 16'h4321; key_digit = 4'd0;
    clear_strobes();
    tick(); tick();
    chk("reset_tries", 32'(tries_left), 32'(MT));
    chk("reset_start", 32'(timer_start), 32'd0);
    rst = 1'b0;

    // Correct PIN.
    card_in = 1'b1; tick();
    chk("insert_restart", 32'(timer_restart), 32'd1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    enter_key(); tick();
    chk("grant_ok", 32'(pin_ok), 32'd1);
    chk("grant_tries", 32'(tries_left), 32'd3);
    tick();

    // Three wrong PINs.
    reinsert();
    for (int a = 0; a < 3; a++) begin
      press(4'd1); press(4'd2); press(4'd3); press(4'd5);
      enter_key(); tick();
      chk("wrong_fail", 32'(pin_fail), 32'd1);
      if (a == 0) begin
        chk("wrong_tries", 32'(tries_left), LOCK_EN ? 32'd2 : 32'd3);
        chk("wrong_restart", 32'(timer_restart), 32'd1);
      end
    end
    chk("lock_level", 32'(locked), 32'(LOCK_EN));
    chk("lock_tries", 32'(tries_left), LOCK_EN ? 32'd0 : 32'd3);
    press(4'd7); tick();
    card_in = 1'b0; tick();
    chk("unlock_on_pull", 32'(locked), 32'd0);

    // Key filtering.
    card_in = 1'b1; tick();
    press(4'hA);
    chk("bad_digit_restart", 32'(timer_restart), 32'd0);
    chk("bad_digit_count", 32'(digits_entered), 32'd0);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'd1);
    chk("fifth_digit", 32'(digits_entered), 32'd4);
    reinsert();
    press(4'd1); press(4'd2); enter_key(); tick();
    chk("short_fail", 32'(pin_fail), 32'd1);

    // Timeout, then timeout racing enter.
    press(4'd1); press(4'd2);
    timer_timeout = 1'b1; tick(); clear_strobes();
    chk("timeout_abort", 32'(aborted), 32'd1);
    chk("timeout_start", 32'(timer_start), 32'd0);
    tick();
    timer_timeout = 1'b1; key_enter = 1'b1; tick(); clear_strobes();
    chk("tmo_vs_enter", 32'(aborted), 32'd1);
    tick();
    press(4'd3); key_cancel = 1'b1; key_valid = 1'b1; key_digit = 4'd4; tick(); clear_strobes();
    tick();

    // Card pull mid-entry, then reset during CHECK.
    press(4'd5);
    card_in = 1'b0; tick();
    chk("pull_no_abort", 32'(aborted), 32'd0);
    card_in = 1'b1; tick();
    press(4'd1); press(4'd2); press(4'd3); press(4'd5);
    enter_key();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_in_check_fail", 32'(pin_fail), 32'd0);
    chk("rst_in_check_digits", 32'(digits_entered), 32'd0);

    // Random traffic.
    card_in = 1'b0; tick();
    for (int c = 0; c < 1500; c++) begin
      if (!card_in) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int i = 0; i < 4; i++) tmp[4*i +: 4] = 4'($urandom_range(0, 9));
          stored_pin = tmp;
          card_in = 1'b1;
        end
      end else if ($urandom_range(0, 99) < ((m_mode >= M_GRANT) ? 15 : 2)) begin
        card_in = 1'b0;
      end
      rst           = ($urandom_range(0, 299) == 0);
      key_valid     = ($urandom_range(0, 99) < 45);
      key_enter     = ($urandom_range(0, 99) < 8);
      key_cancel    = ($urandom_range(0, 99) < 2);
      timer_timeout = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 7 && m_keys.size() < PD)
        key_digit = 4'((stored_pin >> (4*m_keys.size())) & 16'hF);
      else
        key_digit = 4'($urandom_range(0, 15));
      tick();
    end
    clear_strobes(); rst = 1'b0; card_in = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
